// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared types for the synchronous FIFO controller: occupancy-update encoding.
package sync_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // Simultaneous read and write leaves occupancy unchanged.
    function automatic cnt_op_e cnt_op(input logic wr_fire, input logic rd_fire);
        case ({wr_fire, rd_fire})
            2'b10:   return CNT_INC;
            2'b01:   return CNT_DEC;
            default: return CNT_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: synchronous write, combinational read, contents never cleared.
// Read data follows raddr in the same cycle; no flow control of its own.
module dual_port_ram #(
    parameter int DATAWIDTH = 16,
    parameter int ASIZE     = 3
) (
    input  logic                 wclk,
    input  logic                 wrstn,
    input  logic                 wen,
    input  logic [ASIZE-1:0]     waddr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic                 rclk,
    input  logic                 rrstn,
    input  logic                 ren,
    input  logic [ASIZE-1:0]     raddr,
    output logic [DATAWIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DATAWIDTH-1:0] r_mem [0:DEPTH-1];
    logic                 w_unused;

    // Read side is asynchronous, so its clock and reset carry no function here.
    assign w_unused = &{1'b0, rclk, rrstn};

    always_ff @(posedge wclk) begin
        if (wen && wrstn) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = ren ? r_mem[raddr] : '0;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// First-word-fall-through synchronous FIFO; a word written into an empty FIFO is readable next cycle.
// Backpressure: wr_ready = !full, rd_valid = !empty; overflow attempts set sticky ovf_err.
module sync_fifo_ctrl
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int ASIZE     = 3,
    parameter int AFULL_TH  = 6
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATAWIDTH-1:0] wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic [ASIZE:0]       count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 ovf_err
);

    localparam logic [ASIZE:0] PTR_ONE   = {{ASIZE{1'b0}}, 1'b1};
    localparam logic [ASIZE:0] AFULL_CNT = AFULL_TH[ASIZE:0];

    logic [ASIZE:0] r_wr_ptr;
    logic [ASIZE:0] r_rd_ptr;
    logic [ASIZE:0] r_count;
    logic           r_ovf_err;
    logic           w_full;
    logic           w_empty;
    logic           w_wr_fire;
    logic           w_rd_fire;
    cnt_op_e        w_cnt_op;

    // Extra pointer MSB distinguishes a full FIFO from an empty one.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[ASIZE-1:0] == r_rd_ptr[ASIZE-1:0]) &&
                       (r_wr_ptr[ASIZE] != r_rd_ptr[ASIZE]);
    assign w_wr_fire = wr_valid && !w_full && !flush;
    assign w_rd_fire = rd_ready && !w_empty && !flush;
    assign w_cnt_op  = cnt_op(w_wr_fire, w_rd_fire);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf_err <= 1'b0;
        end else if (flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_wr_fire) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_fire) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (wr_valid && w_full) r_ovf_err <= 1'b1;
            case (w_cnt_op)
                CNT_INC: r_count <= r_count + PTR_ONE;
                CNT_DEC: r_count <= r_count - PTR_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    dual_port_ram #(
        .DATAWIDTH (DATAWIDTH),
        .ASIZE     (ASIZE)
    ) u_ram (
        .wclk  (clk),
        .wrstn (rstn),
        .wen   (w_wr_fire),
        .waddr (r_wr_ptr[ASIZE-1:0]),
        .wdata (wr_data),
        .rclk  (clk),
        .rrstn (rstn),
        .ren   (1'b1),
        .raddr (r_rd_ptr[ASIZE-1:0]),
        .rdata (rd_data)
    );

    assign wr_ready    = !w_full;
    assign rd_valid    = !w_empty;
    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = r_count;
    assign almost_full = (r_count >= AFULL_CNT);
    assign ovf_err     = r_ovf_err;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: directed scenarios plus random traffic, scored against a queue model.
module tb_sync_fifo_ctrl;

    localparam int DW       = 16;
    localparam int AS       = 3;
    localparam int DEPTH    = 1 << AS;
    localparam int AFULL_TH = 6;

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [AS:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          ovf_err;

    sync_fifo_ctrl #(.DATAWIDTH(DW), .ASIZE(AS), .AFULL_TH(AFULL_TH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;

    // Reference model: expected stored words in arrival order, plus occupancy and overflow flag.
    logic [DW-1:0] exp_q[$];
    int            m_count = 0;
    bit            m_ovf   = 1'b0;
    bit            mon_en  = 1'b0;
    int            n_cmp   = 0;
    int            n_err   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at the clock edge, using the same inputs the DUT samples.
    initial begin
        forever begin
            @(posedge clk);
            if (!rstn || flush) begin
                exp_q.delete();
                m_count = 0;
                m_ovf   = 1'b0;
            end else begin
                bit w;
                bit r;
                w = wr_valid && (m_count < DEPTH);
                r = rd_ready && (m_count > 0);
                if (wr_valid && m_count == DEPTH) m_ovf = 1'b1;
                if (w) exp_q.push_back(wr_data);
                m_count = m_count + int'(w) - int'(r);
            end
        end
    end

    // Monitor: checks status mid-cycle and pops the head word whenever the DUT offers one.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("count",       32'(count),       32'(m_count));
                chk("empty",       32'(empty),       32'(m_count == 0));
                chk("full",        32'(full),        32'(m_count == DEPTH));
                chk("wr_ready",    32'(wr_ready),    32'(m_count != DEPTH));
                chk("almost_full", 32'(almost_full), 32'(m_count >= AFULL_TH));
                chk("ovf_err",     32'(ovf_err),     32'(m_ovf));
                chk("rd_valid",    32'(rd_valid),    32'(m_count != 0));
                if (rd_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("rd_unexpected", 32'(rd_valid), 32'(0));
                    end else begin
                        chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
                        if (rd_ready && rstn && !flush) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        cyc(0, 0, 0, 0);
        mon_en = 1'b1;
        cyc(0, 0, 0, 0);
        rstn = 1'b1;
        // Idle after reset
        repeat (2) cyc(0, 0, 0, 0);
        // Fill with 1..8 then drain in order
        for (int i = 1; i <= 8; i++) cyc(1, DW'(i), 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
        // Single word into empty FIFO
        cyc(1, 16'hA5A5, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        // Full, write+read together
        for (int i = 0; i < 8; i++) cyc(1, DW'(16'h0010 + i), 0, 0);
        cyc(1, 16'hBEEF, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        // Steady-state streaming at occupancy 3 across pointer wrap
        for (int i = 0; i < 3; i++) cyc(1, DW'(16'h0200 + i), 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, DW'(16'h0100 + i), 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        // Flush at count 5 with overflow set, while writing
        for (int i = 0; i < 8; i++) cyc(1, DW'(16'h0300 + i), 0, 0);
        cyc(1, 16'h0BAD, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        cyc(1, 16'hDEAD, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        // Reset mid-operation
        for (int i = 0; i < 4; i++) cyc(1, DW'(16'h0400 + i), 0, 0);
        rstn = 1'b0;
        cyc(1, 16'h0444, 1, 0);
        rstn = 1'b1;
        cyc(0, 0, 1, 0);
        // Random traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            rstn = ($urandom_range(0, 299) != 0);
            cyc(logic'($urandom_range(0, 99) < 60), DW'($urandom),
                logic'($urandom_range(0, 99) < 50), logic'($urandom_range(0, 79) == 0));
        end
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
